// File: rtl/multiply_pipelined_if.sv
// Operand/product bundle for one pipelined multiply element.
// The parent (or bench) drives the operand side through the master modport.
interface multiply_pipelined_if #(
  parameter int DATA_WIDTH = 16
);
  logic                      en;
  logic                      in_valid;
  logic [DATA_WIDTH-1:0]     a;
  logic [DATA_WIDTH-1:0]     b;
  logic [2*DATA_WIDTH-1:0]   p;
  logic                      out_valid;

  modport master (
    output en,
    output in_valid,
    output a,
    output b,
    input  p,
    input  out_valid
  );

  modport slave (
    input  en,
    input  in_valid,
    input  a,
    input  b,
    output p,
    output out_valid
  );
endinterface

// File: rtl/multiply_pipelined.sv
// Unsigned full-precision multiplier with PIPE_STAGES cycles of latency.
// A valid bit rides alongside the data; en=0 freezes every stage.
// Partitioning:
//   PIPE_STAGES = 1 : product registered straight from the inputs
//   PIPE_STAGES = 2 : operand register, then product register
//   PIPE_STAGES >= 3: operand register, two half-width partial products,
//                     recombined sum, then plain delay stages up to p
module multiply_pipelined #(
  parameter int DATA_WIDTH  = 16,
  parameter int PIPE_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  multiply_pipelined_if.slave  bus
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int LO_W  = DATA_WIDTH / 2;
  localparam int HI_W  = DATA_WIDTH - LO_W;
  localparam int PPL_W = DATA_WIDTH + LO_W;
  localparam int PPH_W = DATA_WIDTH + HI_W;

  if (DATA_WIDTH < 2 || DATA_WIDTH > 64) begin : g_bad_width
    $error("multiply_pipelined: DATA_WIDTH must be in 2..64");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 8) begin : g_bad_stages
    $error("multiply_pipelined: PIPE_STAGES must be in 1..8");
  end

  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES:0]   vld_shift;

  assign vld_shift     = {vld_q, bus.in_valid};
  assign bus.out_valid = vld_q[PIPE_STAGES-1];

  // Valid flag shift register, same depth and enable as the data path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (bus.en) begin
      vld_q <= vld_shift[PIPE_STAGES-1:0];
    end
  end

  if (PIPE_STAGES == 1) begin : g_one
    logic [PW-1:0] prod_q;

    // Single stage: multiply the live inputs and register the product.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_q <= '0;
      end else if (bus.en) begin
        prod_q <= PW'(bus.a) * PW'(bus.b);
      end
    end

    assign bus.p = prod_q;

  end else begin : g_multi
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;

    // Stage 1: capture the operand pair.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
      end else if (bus.en) begin
        a_q <= bus.a;
        b_q <= bus.b;
      end
    end

    if (PIPE_STAGES == 2) begin : g_two
      logic [PW-1:0] prod_q;

      // Stage 2: full product of the captured operands.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prod_q <= '0;
        end else if (bus.en) begin
          prod_q <= PW'(a_q) * PW'(b_q);
        end
      end

      assign bus.p = prod_q;

    end else begin : g_split
      logic [PPL_W-1:0] pp_lo_q;
      logic [PPH_W-1:0] pp_hi_q;
      logic [PW-1:0]    sum;
      logic [PW-1:0]    prod_q [PIPE_STAGES-2];

      // Stage 2: a times each half of b, kept as separate partial products.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pp_lo_q <= '0;
          pp_hi_q <= '0;
        end else if (bus.en) begin
          pp_lo_q <= PPL_W'(a_q) * PPL_W'(b_q[LO_W-1:0]);
          pp_hi_q <= PPH_W'(a_q) * PPH_W'(b_q[DATA_WIDTH-1:LO_W]);
        end
      end

      // The high partial product is weighted by 2**LO_W before adding.
      assign sum = {pp_hi_q, {LO_W{1'b0}}} + PW'(pp_lo_q);

      // Stage 3 registers the complete product; any further stages only delay it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PIPE_STAGES - 2; i++) begin
            prod_q[i] <= '0;
          end
        end else if (bus.en) begin
          prod_q[0] <= sum;
          for (int i = 1; i < PIPE_STAGES - 2; i++) begin
            prod_q[i] <= prod_q[i-1];
          end
        end
      end

      assign bus.p = prod_q[PIPE_STAGES-3];
    end
  end

endmodule

// File: tb/tb_multiply_pipelined.sv
// Bench for multiply_pipelined: one main instance (16 bit, 3 stages) plus
// three sweep instances sharing the same stimulus, all checked every cycle
// against a history-based reference, with directed checks on the main one.
module tb_multiply_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drv_en = 1'b1;
  logic        drv_v  = 1'b0;
  logic [63:0] drv_a  = '0;
  logic [63:0] drv_b  = '0;

  int n_checks = 0;
  int n_pass   = 0;

  // Operand history of every accepted edge since the last reset.
  logic [63:0] hist_a [$];
  logic [63:0] hist_b [$];
  logic        hist_v [$];

  always #5 clk = ~clk;

  multiply_pipelined_if #(.DATA_WIDTH(16)) if_main ();
  multiply_pipelined_if #(.DATA_WIDTH(8))  if_s0 ();
  multiply_pipelined_if #(.DATA_WIDTH(16)) if_s1 ();
  multiply_pipelined_if #(.DATA_WIDTH(32)) if_s2 ();

  assign if_main.en = drv_en;  assign if_main.in_valid = drv_v;
  assign if_main.a  = drv_a[15:0];  assign if_main.b = drv_b[15:0];
  assign if_s0.en   = drv_en;  assign if_s0.in_valid = drv_v;
  assign if_s0.a    = drv_a[7:0];   assign if_s0.b = drv_b[7:0];
  assign if_s1.en   = drv_en;  assign if_s1.in_valid = drv_v;
  assign if_s1.a    = drv_a[15:0];  assign if_s1.b = drv_b[15:0];
  assign if_s2.en   = drv_en;  assign if_s2.in_valid = drv_v;
  assign if_s2.a    = drv_a[31:0];  assign if_s2.b = drv_b[31:0];

  multiply_pipelined #(.DATA_WIDTH(16), .PIPE_STAGES(3)) u_main (.clk(clk), .rst(rst), .bus(if_main));
  multiply_pipelined #(.DATA_WIDTH(8),  .PIPE_STAGES(1)) u_s0   (.clk(clk), .rst(rst), .bus(if_s0));
  multiply_pipelined #(.DATA_WIDTH(16), .PIPE_STAGES(2)) u_s1   (.clk(clk), .rst(rst), .bus(if_s1));
  multiply_pipelined #(.DATA_WIDTH(32), .PIPE_STAGES(5)) u_s2   (.clk(clk), .rst(rst), .bus(if_s2));

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output after n accepted edges is the pair accepted ps edges ago, or
  // the reset value if fewer than ps edges have been accepted.
  task automatic check_model(input string tag, input int ps, input int dw,
                             input logic [127:0] obs_p, input logic obs_v);
    int            n;
    logic [127:0]  mask;
    logic [127:0]  ep;
    logic          ev;
    n    = hist_v.size();
    mask = (128'd1 << dw) - 128'd1;
    if (n < ps) begin
      ep = '0;
      ev = 1'b0;
    end else begin
      ep = ({64'd0, hist_a[n-ps]} & mask) * ({64'd0, hist_b[n-ps]} & mask);
      ev = hist_v[n-ps];
    end
    check_eq({tag, "_valid"}, {127'd0, obs_v}, {127'd0, ev});
    check_eq({tag, "_p"}, obs_p, ep);
  endtask

  task automatic check_all_models();
    check_model("main", 3, 16, 128'(if_main.p), if_main.out_valid);
    check_model("s0",   1, 8,  128'(if_s0.p),   if_s0.out_valid);
    check_model("s1",   2, 16, 128'(if_s1.p),   if_s1.out_valid);
    check_model("s2",   5, 32, 128'(if_s2.p),   if_s2.out_valid);
  endtask

  task automatic clear_history();
    hist_a.delete();
    hist_b.delete();
    hist_v.delete();
  endtask

  // One clock edge: record what the DUTs accept, then check after settling.
  task automatic tick();
    @(posedge clk);
    if (!rst && drv_en) begin
      hist_a.push_back(drv_a);
      hist_b.push_back(drv_b);
      hist_v.push_back(drv_v);
    end
    #1;
    check_all_models();
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b);
    drv_v = 1'b1;
    drv_a = a;
    drv_b = b;
    tick();
  endtask

  task automatic bubble();
    drv_v = 1'b0;
    drv_a = '0;
    drv_b = '0;
    tick();
  endtask

  task automatic check_main(input string tag, input logic [31:0] ep, input logic ev);
    check_eq({tag, "_valid"}, {127'd0, if_main.out_valid}, {127'd0, ev});
    if (ev) check_eq({tag, "_p"}, 128'(if_main.p), 128'(ep));
  endtask

  initial begin
    // Reset state, with en high across reset edges (reset must win).
    #1;
    check_main("reset", 32'd0, 1'b0);
    check_eq("reset_p", 128'(if_main.p), 128'd0);
    check_all_models();
    @(posedge clk); @(posedge clk);
    #1;
    check_all_models();
    @(negedge clk);
    rst = 1'b0;

    // Single max*max pair, out_valid high for exactly one cycle.
    issue(64'hFFFF, 64'hFFFF);
    drv_v = 1'b0; drv_a = '0; drv_b = '0;
    check_main("t1_e0", 32'd0, 1'b0);
    tick();
    check_main("t1_e1", 32'd0, 1'b0);
    tick();
    check_main("t1_e2", 32'hFFFE0001, 1'b1);
    tick();
    check_main("t1_after", 32'd0, 1'b0);

    // Back-to-back pairs emerge in order.
    issue(64'd3, 64'd5);
    issue(64'd0, 64'd1234);
    issue(64'h00FF, 64'h0100);
    check_main("t2_first", 32'd15, 1'b1);
    bubble();
    check_main("t2_second", 32'd0, 1'b1);
    bubble();
    check_main("t2_third", 32'h0000FF00, 1'b1);
    bubble();
    check_main("t2_after", 32'd0, 1'b0);
    bubble(); bubble();

    // Stall for 4 cycles after the operand stage captured (7,9).
    issue(64'd7, 64'd9);
    drv_v = 1'b0; drv_a = 64'h1234; drv_b = 64'h4321;
    drv_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_main("t3_stall", 32'd0, 1'b0);
      check_eq("t3_stall_p", 128'(if_main.p), 128'd0);
    end
    drv_en = 1'b1; drv_a = '0; drv_b = '0;
    tick();
    check_main("t3_edge2", 32'd0, 1'b0);
    tick();
    check_main("t3_result", 32'd63, 1'b1);
    tick();
    check_main("t3_once", 32'd0, 1'b0);
    bubble(); bubble();

    // Asynchronous reset while (100,200) is in flight.
    issue(64'd100, 64'd200);
    bubble();
    #2;
    rst = 1'b1;
    clear_history();
    #1;
    check_main("t4_rst", 32'd0, 1'b0);
    check_eq("t4_rst_p", 128'(if_main.p), 128'd0);
    check_all_models();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bubble();
      check_main("t4_no_stale", 32'd0, 1'b0);
    end
    issue(64'd2, 64'd2);
    bubble();
    bubble();
    check_main("t4_after", 32'd4, 1'b1);
    bubble(); bubble();

    // Boundary operands; upper half of the product must stay zero.
    issue(64'd0, 64'hFFFF);
    issue(64'd1, 64'hFFFF);
    issue(64'hFFFF, 64'd1);
    check_main("t6_zero", 32'd0, 1'b1);
    check_eq("t6_zero_hi", 128'(if_main.p[31:16]), 128'd0);
    bubble();
    check_main("t6_one_max", 32'h0000FFFF, 1'b1);
    check_eq("t6_one_max_hi", 128'(if_main.p[31:16]), 128'd0);
    bubble();
    check_main("t6_max_one", 32'h0000FFFF, 1'b1);
    check_eq("t6_max_one_hi", 128'(if_main.p[31:16]), 128'd0);
    bubble(); bubble(); bubble(); bubble(); bubble();

    // Randomized pairs with bubbles and stalls, all instances vs the model.
    for (int i = 0; i < 1000; i++) begin
      drv_en = ($urandom_range(0, 99) < 85);
      drv_v  = ($urandom_range(0, 99) < 80);
      case ($urandom_range(0, 9))
        0:       begin drv_a = '1; drv_b = '1; end
        1:       begin drv_a = '0; drv_b = {$urandom, $urandom}; end
        default: begin drv_a = {$urandom, $urandom}; drv_b = {$urandom, $urandom}; end
      endcase
      tick();
    end
    drv_en = 1'b1;
    for (int i = 0; i < 6; i++) bubble();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multiply_pipelined.md
Name: multiply_pipelined

Overview:
- Unsigned integer multiplier with a fixed-latency pipeline and a valid flag that travels with each operand pair.
- Used as the scalar multiply element inside the matrix multiplier array: one instance per A[i][k]*B[k][j] product.
- Products feed a combinational adder tree.
- out_valid feeds the array's calc_done AND-reduction.

Parameters:
- DATA_WIDTH, 16, bit width of each operand. Legal range 2..64.
- PIPE_STAGES, 3, number of register stages from input to output, equal to the latency in cycles. Legal range 1..8. Any value outside this range is an elaboration-time error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  pipeline advance enable; 0 stalls every stage
- in_valid  input  1  a/b carry a valid operand pair this cycle
- a  input  DATA_WIDTH  multiplicand, unsigned
- b  input  DATA_WIDTH  multiplier, unsigned
- p  output  2*DATA_WIDTH  registered full-precision product, unsigned
- out_valid  output  1  p holds the product of a valid pair

Behaviour:
- Reset: rst high clears every pipeline data register and valid bit immediately, independent of clk.
  - p=0 and out_valid=0 while rst is high.
  - First capture happens on the first rising edge after rst deasserts.
- Arithmetic:
  - p = a*b, unsigned, full 2*DATA_WIDTH width. No truncation, overflow or rounding is possible.
  - Width reduction is the parent's job.
- Latency:
  - With en held high, operands sampled on edge N appear on p on edge N+PIPE_STAGES-1. That is PIPE_STAGES register stages, including the output register.
  - Throughput is one new pair per cycle.
  - Back-to-back pairs emerge in order, one per cycle.
- Valid pipeline:
  - in_valid is shifted alongside the data and emerges as out_valid with identical latency.
  - Data stages advance regardless of in_valid.
  - With in_valid=0, p still updates to a*b of whatever was on the inputs. Consumers qualify p with out_valid.
- Stall:
  - When en=0 at an edge, all data and valid registers hold.
  - No sample is taken, none is lost or duplicated.
  - p and out_valid stay constant for the whole stall.
  - Resuming en=1 continues exactly where the pipeline stopped.
- Stage partitioning:
  - When PIPE_STAGES >= 2, stage 1 registers the operands.
  - The multiplication may be split into partial-product sums across the middle stages.
  - The final stage registers the complete product.
  - Internal partitioning is free, provided the latency and result rules hold for every legal PIPE_STAGES.
- PIPE_STAGES=1: the single stage registers a*b directly from the inputs.
- Reset mid-operation: all in-flight pairs are discarded. No stale out_valid pulse may appear after rst deasserts.
- Simultaneous rst and en: rst wins.
- No internal state beyond the pipeline registers. No X propagation out of reset: every register has a reset value.

Test Plan:
1. DATA_WIDTH=16, PIPE_STAGES=3, en=1. Apply a=0xFFFF, b=0xFFFF, in_valid=1 for one cycle at edge 0 -> p=0xFFFE0001 with out_valid=1 for exactly one cycle, at edge 2. out_valid=0 before and after.
2. Back-to-back pairs (3,5), (0,1234), (0x00FF,0x0100) on consecutive edges -> p = 15, 0, 0xFF00 on three consecutive cycles, out_valid high for all three.
3. Stall: issue (7,9). Drop en for 4 cycles after the first stage has captured it -> p and out_valid frozen during the stall. After en returns high, p=63 with out_valid=1 exactly PIPE_STAGES active edges after issue, and appears once only.
4. Reset mid-flight: issue (100,200), then assert rst asynchronously between edges before it reaches the output -> p=0 and out_valid=0 immediately. No out_valid pulse after release; the next issued pair (2,2) yields p=4 at normal latency.
5. Parameter sweep over PIPE_STAGES in {1,2,5} and DATA_WIDTH in {8,16,32} with 1000 random valid pairs -> every p equals the reference full-width product at latency PIPE_STAGES. A bubble with in_valid=0 produces out_valid=0 in the matching slot.
6. Boundary operands a=0 / b=max, a=1 / b=max, a=max / b=1 -> p = 0, max, max. Upper half zero in all three cases.
